// File: rtl/seg_hex_collector_if.sv
// Segment-digit in / 32-bit word out bundle for seg_hex_collector.
// master = digit producer and word consumer, slave = the collector.
interface seg_hex_collector_if;
  logic [6:0]  seg_in;
  logic        seg_valid;
  logic        word_ready;
  logic [31:0] word_out;
  logic        word_valid;
  logic        bad_digit;
  logic        overrun;
  logic [2:0]  digit_count;

  modport master (
    output seg_in, seg_valid, word_ready,
    input  word_out, word_valid, bad_digit, overrun, digit_count
  );

  modport slave (
    input  seg_in, seg_valid, word_ready,
    output word_out, word_valid, bad_digit, overrun, digit_count
  );
endinterface

// File: rtl/seg_hex_collector.sv
// Collects eight active-low 7-segment digits into a 32-bit hex word and holds it
// until consumed. Optional macro SEG_BLANK_EN: decode 7F (blank) as 0 without bad_digit.
module seg_hex_collector (
  input  logic                       clk,
  input  logic                       rst,
  seg_hex_collector_if.slave         bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] word_q,  word_d;
  logic        bad_q,   bad_d;
  logic        ovr_q,   ovr_d;
  logic [2:0]  cnt_q,   cnt_d;

  logic [3:0]  dec_nib;
  logic        dec_bad;
  logic        take;

  always_comb begin
    dec_nib = '0;
    dec_bad = 1'b0;
    case (bus.seg_in)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h18: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
`ifdef SEG_BLANK_EN
      7'h7F: dec_nib = 4'h0;
`endif
      default: begin
        dec_nib = 4'h0;
        dec_bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bad_d   = bad_q;
    cnt_d   = cnt_q;
    ovr_d   = 1'b0;
    take    = 1'b0;

    case (state_q)
      ST_IDLE, ST_FILL: take = bus.seg_valid;
      ST_HOLD: begin
        if (bus.word_ready) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          bad_d   = 1'b0;
          take    = bus.seg_valid;
        end else begin
          ovr_d = bus.seg_valid;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        bad_d   = 1'b0;
      end
    endcase

    // cnt_q is already 0 in HOLD, so a same-cycle handshake digit lands as digit 1
    if (take) begin
      word_d = {word_q[27:0], dec_nib};
      bad_d  = bad_d | dec_bad;
      if (cnt_q == 3'd7) begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end else begin
        state_d = ST_FILL;
        cnt_d   = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      bad_q   <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bad_q   <= bad_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.word_out    = word_q;
  assign bus.word_valid  = (state_q == ST_HOLD);
  assign bus.bad_digit   = bad_q;
  assign bus.overrun     = ovr_q;
  assign bus.digit_count = cnt_q;

endmodule

// File: tb/tb_seg_hex_collector.sv
// Scoreboard bench for seg_hex_collector: directed cases then randomized traffic
// against a digit-list reference model.
module tb_seg_hex_collector;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_hex_collector_if bus ();

  seg_hex_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [6:0] pat_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: position of the pattern in the table is the digit value
  function automatic int ref_decode(input logic [6:0] s, output bit bad);
    bad = 1'b0;
`ifdef SEG_BLANK_EN
    if (s == 7'h7F) return 0;
`endif
    for (int i = 0; i < 16; i++)
      if (pat_tab[i] == s) return i;
    bad = 1'b1;
    return 0;
  endfunction

  // Reference model state
  int          digits[$];
  bit          m_bad;
  bit          m_hold;
  bit          m_ovr;
  typedef struct { logic [31:0] word; bit bad; } exp_t;
  exp_t        sb[$];

  task automatic model_accept(input logic [6:0] s);
    bit   b;
    int   v;
    logic [31:0] w;
    v = ref_decode(s, b);
    digits.push_back(v);
    m_bad = m_bad | b;
    if (digits.size() == 8) begin
      w = '0;
      for (int i = 0; i < 8; i++) w = w + (32'(digits[i]) << (4 * (7 - i)));
      sb.push_back('{w, m_bad});
      digits.delete();
      m_hold = 1'b1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      digits.delete();
      sb.delete();
      m_bad  = 1'b0;
      m_hold = 1'b0;
      m_ovr  = 1'b0;
    end else if (m_hold) begin
      if (bus.word_ready) begin
        m_hold = 1'b0;
        m_bad  = 1'b0;
        m_ovr  = 1'b0;
        if (bus.seg_valid) model_accept(bus.seg_in);
      end else begin
        m_ovr = bus.seg_valid;
      end
    end else begin
      m_ovr = 1'b0;
      if (bus.seg_valid) model_accept(bus.seg_in);
    end
  end

  // Monitor: per-cycle status checks, word checks popped from the scoreboard
  bit          prev_valid = 1'b0;
  exp_t        cur;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      chk("word_valid",  32'(bus.word_valid),  32'(m_hold));
      chk("digit_count", 32'(bus.digit_count), 32'(digits.size()));
      chk("overrun",     32'(bus.overrun),     32'(m_ovr));
      if (bus.word_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL sb_empty: word_valid with no expected word, got %h", bus.word_out);
          cur = '{bus.word_out, bus.bad_digit};
        end else begin
          cur = sb.pop_front();
        end
      end
      if (bus.word_valid) begin
        chk("word_out",  bus.word_out,        cur.word);
        chk("bad_held",  32'(bus.bad_digit),  32'(cur.bad));
      end else begin
        chk("bad_fill",  32'(bus.bad_digit),  32'(m_bad));
      end
      prev_valid = bus.word_valid;
    end
  end

  task automatic drive(input logic v, input logic [6:0] s, input logic r);
    bus.seg_valid  = v;
    bus.seg_in     = s;
    bus.word_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_word"},  bus.word_out,           32'h0);
    chk({tag, "_valid"}, 32'(bus.word_valid),    32'h0);
    chk({tag, "_bad"},   32'(bus.bad_digit),     32'h0);
    chk({tag, "_ovr"},   32'(bus.overrun),       32'h0);
    chk({tag, "_cnt"},   32'(bus.digit_count),   32'h0);
  endtask

  logic [6:0] seq_a [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
  logic [6:0] seq_b [8] = '{7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] seq_c [8] = '{7'h40, 7'h79, 7'h7F, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  initial begin
    bus.seg_in     = '0;
    bus.seg_valid  = 1'b0;
    bus.word_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Ascending digits, held
    for (int i = 0; i < 8; i++) drive(1'b1, seq_a[i], 1'b0);
    chk("d025_valid", 32'(bus.word_valid), 32'h1);
    chk("d025_word",  bus.word_out, 32'h01234567);
    chk("d025_bad",   32'(bus.bad_digit), 32'h0);
    drive(1'b0, 7'h0, 1'b0);
    drive(1'b0, 7'h0, 1'b1);
    drive(1'b0, 7'h0, 1'b0);

    // Consumer always ready: word visible for a single cycle
    for (int i = 0; i < 8; i++) drive(1'b1, seq_b[i], 1'b1);
    chk("d026_word",  bus.word_out, 32'h89ABCDEF);
    drive(1'b0, 7'h0, 1'b1);
    chk("d026_valid_gone", 32'(bus.word_valid), 32'h0);
    chk("d026_cnt",        32'(bus.digit_count), 32'h0);
    drive(1'b0, 7'h0, 1'b0);

    // Blank pattern in third position
    for (int i = 0; i < 8; i++) drive(1'b1, seq_c[i], 1'b0);
    chk("d027_nib", 32'(bus.word_out[23:20]), 32'h0);
`ifdef SEG_BLANK_EN
    chk("d027_bad", 32'(bus.bad_digit), 32'h0);
`else
    chk("d027_bad", 32'(bus.bad_digit), 32'h1);
`endif
    drive(1'b0, 7'h0, 1'b1);
    drive(1'b0, 7'h0, 1'b0);

    // Overrun, then handshake with a same-cycle digit
    for (int i = 0; i < 8; i++) drive(1'b1, seq_a[i], 1'b0);
    drive(1'b1, 7'h79, 1'b0);
    chk("d028_ovr",  32'(bus.overrun), 32'h1);
    chk("d028_hold", bus.word_out, 32'h01234567);
    drive(1'b1, 7'h24, 1'b1);
    chk("d028_ovr_clr", 32'(bus.overrun), 32'h0);
    chk("d028_cnt",     32'(bus.digit_count), 32'h1);
    chk("d028_nib",     32'(bus.word_out[3:0]), 32'h2);
    drive(1'b0, 7'h0, 1'b0);

    // Asynchronous reset mid-fill
    for (int i = 0; i < 5; i++) drive(1'b1, seq_b[i], 1'b0);
    bus.seg_valid = 1'b0;
    #3 rst = 1'b1;
    #1 chk_all_zero("d029_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) drive(1'b1, 7'h40, 1'b0);
    chk("d029_valid", 32'(bus.word_valid), 32'h1);
    chk("d029_word",  bus.word_out, 32'h00000000);
    drive(1'b0, 7'h0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic [6:0] s;
      if ($urandom_range(99) < 80) s = pat_tab[$urandom_range(15)];
      else                         s = 7'($urandom);
      if ($urandom_range(599) == 0) begin
        rst = 1'b1;
        drive(1'b0, 7'h0, 1'b0);
        rst = 1'b0;
      end else begin
        drive(1'($urandom_range(99) < 60), s, 1'($urandom_range(99) < 40));
      end
    end

    drive(1'b0, 7'h0, 1'b0);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
